shift_seq: RTL



---
 rtl/shift_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Iterative shifter: one bit per cycle, computing logical left, logical right or
// arithmetic right by 0..WIDTH-1. Valid/ready handshakes on operand and result sides.
module shift_seq #(
    parameter int WIDTH = 32,
    localparam int SAW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] X,
    input  logic [SAW-1:0]   Sa,
    input  logic             IsArith,
    input  logic             IsRight,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] r;
    logic [SAW-1:0]   cnt;
    logic             isArithQ;
    logic             isRightQ;

    // One step of the shift; arithmetic right replicates the sign bit.
    function automatic logic [WIDTH-1:0] shiftOne(
        input logic [WIDTH-1:0] d,
        input logic             right,
        input logic             arith
    );
        logic signed [WIDTH-1:0] s;
        s = signed'(d);
        if (!right)
            return d << 1;
        else if (arith)
            return $unsigned(s >>> 1);
        else
            return d >> 1;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (InValid) stateNext = (Sa == '0) ? HOLD : SHIFT;
            SHIFT:   if (cnt == SAW'(1)) stateNext = HOLD;
            HOLD:    if (OutReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operands are captured only on the accept edge; R then shifts in place.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r        <= '0;
            cnt      <= '0;
            isArithQ <= 1'b0;
            isRightQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        r        <= X;
                        cnt      <= Sa;
                        isArithQ <= IsArith;
                        isRightQ <= IsRight;
                    end
                end
                SHIFT: begin
                    r   <= shiftOne(r, isRightQ, isArithQ);
                    cnt <= cnt - SAW'(1);
                end
                default: ;
            endcase
        end
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == HOLD);
    assign Y        = r;

endmodule
